seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving clock cycles per digit slot (legal range 2..2^20).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port din, input, 16 bits: the value to display; digit3 = din[15:12] ... digit0 = din[3:0].
REQ-005 The block SHALL have port cin, input, 1 bit: the carry-out of the upstream 4-bit ripple adder, shown on the digit3 decimal point.
REQ-006 The block SHALL have port load, input, 1 bit: capture strobe for din and cin.
REQ-007 The block SHALL have port ack, output, 1 bit: one-cycle pulse confirming a capture.
REQ-008 The block SHALL have port dout, output, 7 bits: active-low segments, bit0 = a ... bit6 = g.
REQ-009 The block SHALL have port an, output, 4 bits: active-low digit enables, where an[i] selects digit i.
REQ-010 The block SHALL have port dp, output, 1 bit: active-low decimal point.

Function
REQ-011 A prescaler SHALL count 0..DIV-1, wrapping to 0 after DIV-1; tick is asserted in the cycle where the count equals DIV-1.
REQ-012 The scan FSM SHALL have states DIG0 -> DIG1 -> DIG2 -> DIG3 -> DIG0, advancing only on tick; one full scan takes 4*DIV cycles.
REQ-013 an SHALL be all ones except for a single 0 at the current digit index (DIG0 = 4'b1110, DIG3 = 4'b0111), and SHALL never have two zeros.
REQ-014 dout SHALL be the hex decode of the current digit nibble of the display register:
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
- 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
- 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
- C = 1000110, d = 0100001, E = 0000110, F = 0001110
REQ-015 dout, an and dp SHALL be combinational from registered state only and SHALL change on the same edge as the FSM state.
REQ-016 dp SHALL be 0 only while in DIG3 with the displayed carry equal to 1; otherwise dp SHALL be 1.
REQ-017 On load=1 at edge N, din and cin SHALL be written to a pending register, and ack SHALL be 1 for the cycle following edge N only.
REQ-018 On each tick, the pending register SHALL be copied to the display register, so a new value becomes visible only at a digit-slot boundary (no mid-slot tearing).
REQ-019 If load and tick occur at the same edge, the display register SHALL receive the old pending value and the pending register SHALL receive din; the new value becomes visible at the next tick.
REQ-020 Back-to-back loads SHALL be accepted every cycle (last value wins), with ack high in every cycle following a load.
REQ-021 Holding load high SHALL re-capture din every cycle; no load SHALL ever be refused.

Reset
REQ-022 While rst=1 at an edge, the block SHALL clear:
- prescaler to 0
- FSM to DIG0
- pending and display registers to 0, carry to 0
- ack to 0
REQ-023 Outputs after reset SHALL be an=4'b1110, dout=7'b1000000, dp=1, ack=0.
REQ-024 A load coinciding with rst SHALL be ignored, and a pending value not yet displayed SHALL be discarded by reset.
REQ-025 Reset mid-slot SHALL restart the slot timing, so the next tick occurs DIV cycles after rst deasserts.

Configuration
REQ-026 Macro SEG_LEAD_ZERO_BLANK_EN SHALL control leading-zero blanking.
- Defined: leading zero nibbles, counted from digit3 downward, SHALL drive dout=7'b1111111 in their slot; digit0 is never blanked; dp behaviour is unchanged; an timing is unchanged.
- Undefined: all four digits SHALL always be decoded.

Verification (DIV=4)
REQ-027 Reset, then run 16 cycles -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110; dout=1000000 throughout.
REQ-028 load with din=16'h1A3F, cin=1 at count 1 -> ack high for 1 cycle; dout unchanged until the tick; then the scan shows 0001110 (F), 0110000 (3), 0001000 (A), 1111001 (1), with dp=0 only in DIG3.
REQ-029 load din=16'h0005 coincident with tick, after an earlier load of 16'h0001 -> the following slot shows value 1 and the slot after that shows value 5.
REQ-030 Loads of 16'h1111 then 16'h2222 on consecutive cycles -> ack high for 2 cycles; 2222 is displayed and 1111 is never shown.
REQ-031 rst asserted at count 2 of DIG2 with a load pending -> an=1110 and dout=1000000 on the next cycle; the pending value is never displayed.
REQ-032 With SEG_LEAD_ZERO_BLANK_EN defined and din=16'h0040 -> digits 3 and 2 show 1111111, digit1 shows 0011001, digit0 shows 1000000; with the macro undefined, digits 3 and 2 show 1000000.

Source files
------------

// File: rtl/seg_scan_if.sv
// ---------------------------------------------------------------------------
// seg_scan_if
// Bundles the data/handshake side and the display side of seg_scan_driver.
//   din  [15:0] : value to display, digit3 = din[15:12] ... digit0 = din[3:0]
//   cin         : upstream adder carry-out, shown on the digit3 decimal point
//   load        : capture strobe for din/cin
//   ack         : one-cycle pulse confirming a capture
//   dout [6:0]  : active-low segments, bit0 = a ... bit6 = g
//   an   [3:0]  : active-low digit enables, an[i] selects digit i
//   dp          : active-low decimal point
// master drives din/cin/load; slave (the driver) drives ack/dout/an/dp.
// ---------------------------------------------------------------------------
interface seg_scan_if;
    logic [15:0] din;
    logic        cin;
    logic        load;
    logic        ack;
    logic [6:0]  dout;
    logic [3:0]  an;
    logic        dp;

    modport master (
        output din, cin, load,
        input  ack, dout, an, dp
    );

    modport slave (
        input  din, cin, load,
        output ack, dout, an, dp
    );
endinterface

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler produces one tick every DIV cycles; each tick advances the
// scan FSM to the next digit and copies the pending value into the display
// register, so new values only appear at digit-slot boundaries.
//
// Parameters
//   DIV  : clock cycles per digit slot (2 .. 2^20)
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seg_scan_if.slave (din, cin, load in; ack, dout, an, dp out)
// Build option
//   SEG_LEAD_ZERO_BLANK_EN : when defined, leading zero digits (from digit3
//   downward, never digit0) are blanked; an/dp timing is unaffected.
// ---------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);

    localparam int             CW      = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tick;

    logic [15:0]    pend_val_q;
    logic           pend_c_q;
    logic [15:0]    disp_val_q;
    logic           disp_c_q;
    logic           ack_q;

    logic [3:0]     an_c;
    logic [6:0]     dout_c;
    logic           dp_c;
    logic [3:0]     nib_c;
    logic           blank_c;

    // Active-low hex decode, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Prescaler: tick marks the last cycle of each digit slot.
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIG0;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: advance one digit per tick.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                DIG0:    state_d = DIG1;
                DIG1:    state_d = DIG2;
                DIG2:    state_d = DIG3;
                default: state_d = DIG0;
            endcase
        end
    end

    // Prescaler, capture and display registers. On a simultaneous load and
    // tick the display takes the old pending value while pending takes din,
    // so the fresh value waits for the following slot boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            pend_val_q <= '0;
            pend_c_q   <= 1'b0;
            disp_val_q <= '0;
            disp_c_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ack_q <= bus.load;
            if (bus.load) begin
                pend_val_q <= bus.din;
                pend_c_q   <= bus.cin;
            end
            if (tick) begin
                disp_val_q <= pend_val_q;
                disp_c_q   <= pend_c_q;
            end
        end
    end

    // FSM outputs: purely from registered state, so they change on the
    // same edge as the FSM.
    always_comb begin
        an_c    = 4'b1111;
        nib_c   = disp_val_q[3:0];
        blank_c = 1'b0;
        case (state_q)
            DIG0: begin
                an_c  = 4'b1110;
                nib_c = disp_val_q[3:0];
            end
            DIG1: begin
                an_c  = 4'b1101;
                nib_c = disp_val_q[7:4];
`ifdef SEG_LEAD_ZERO_BLANK_EN
                blank_c = (disp_val_q[15:4] == 12'h000);
`endif
            end
            DIG2: begin
                an_c  = 4'b1011;
                nib_c = disp_val_q[11:8];
`ifdef SEG_LEAD_ZERO_BLANK_EN
                blank_c = (disp_val_q[15:8] == 8'h00);
`endif
            end
            default: begin
                an_c  = 4'b0111;
                nib_c = disp_val_q[15:12];
`ifdef SEG_LEAD_ZERO_BLANK_EN
                blank_c = (disp_val_q[15:12] == 4'h0);
`endif
            end
        endcase
        dout_c = blank_c ? 7'b1111111 : hex_to_seg(nib_c);
        dp_c   = !((state_q == DIG3) && disp_c_q);
    end

    assign bus.an   = an_c;
    assign bus.dout = dout_c;
    assign bus.dp   = dp_c;
    assign bus.ack  = ack_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
// Directed bench for seg_scan_driver with DIV = 4. Each stimulus cycle
// pushes the expected an/dout/dp/ack for the state after that edge into a
// queue; a monitor on the falling edge pops and compares. The visible value
// for every cycle is written by hand in the stimulus; segment codes come
// from a constant table. Honours SEG_LEAD_ZERO_BLANK_EN when defined.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int DIV = 4;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] dout;
        logic       dp;
        logic       ack;
    } exp_t;

    logic clk;
    logic rst;
    int   k;
    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];

    seg_scan_if bus_if ();

    seg_scan_driver #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] exp_dout(input logic [15:0] v, input int slot);
        logic blank;
        blank = 1'b0;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        if (slot > 0) begin
            blank = 1'b1;
            for (int j = 3; j >= slot; j--)
                if (v[j*4 +: 4] != 4'h0) blank = 1'b0;
        end
`endif
        return blank ? 7'b1111111 : seg_ref(v[slot*4 +: 4]);
    endfunction

    // One clock edge: drive inputs, take the edge, queue the expected outputs.
    task automatic step(input logic r, input logic ld, input logic [15:0] d,
                        input logic c, input logic [15:0] vis, input logic vc);
        exp_t rec;
        int   slot;
        rst         = r;
        bus_if.load = ld;
        bus_if.din  = d;
        bus_if.cin  = c;
        @(posedge clk);
        if (r) k = 0;
        else   k = k + 1;
        slot     = (k / DIV) % 4;
        rec.k    = k;
        rec.an   = ~(4'b0001 << slot);
        rec.dout = exp_dout(vis, slot);
        rec.dp   = !((slot == 3) && vc);
        rec.ack  = ld && !r;
        exp_q.push_back(rec);
        #1;
    endtask

    task automatic run(input int n, input logic [15:0] vis, input logic vc);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, vis, vc);
    endtask

    task automatic ldcyc(input logic [15:0] d, input logic c,
                         input logic [15:0] vis, input logic vc);
        step(1'b0, 1'b1, d, c, vis, vc);
    endtask

    // Monitor: the display is valid every cycle once an edge has been queued.
    always @(negedge clk) begin
        exp_t rec;
        if (exp_q.size() > 0) begin
            rec   = exp_q.pop_front();
            n_chk = n_chk + 1;
            if (bus_if.an !== rec.an || bus_if.dout !== rec.dout ||
                bus_if.dp !== rec.dp || bus_if.ack !== rec.ack) begin
                n_fail = n_fail + 1;
                $display("FAIL scan k=%0d: got an=%b dout=%b dp=%b ack=%b, want an=%b dout=%b dp=%b ack=%b",
                         rec.k, bus_if.an, bus_if.dout, bus_if.dp, bus_if.ack,
                         rec.an, rec.dout, rec.dp, rec.ack);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        k           = 0;
        rst         = 1'b1;
        bus_if.load = 1'b0;
        bus_if.din  = 16'h0000;
        bus_if.cin  = 1'b0;

        // Reset, with a load during reset that must be ignored.
        step(1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Idle scan: four slots of four cycles, then wrap to digit 0.
        run(16, 16'h0000, 1'b0);                 // k = 1..16

        // Load 1A3F/carry mid-slot; visible only from the next slot boundary.
        run(1, 16'h0000, 1'b0);                  // k = 17
        ldcyc(16'h1A3F, 1'b1, 16'h0000, 1'b0);   // k = 18
        run(1, 16'h0000, 1'b0);                  // k = 19
        run(16, 16'h1A3F, 1'b1);                 // k = 20..35

        // Load 0001, then load 0005 on a tick edge: 0001 shows first.
        run(1, 16'h1A3F, 1'b1);                  // k = 36
        ldcyc(16'h0001, 1'b0, 16'h1A3F, 1'b1);   // k = 37
        run(2, 16'h1A3F, 1'b1);                  // k = 38..39
        ldcyc(16'h0005, 1'b0, 16'h0001, 1'b0);   // k = 40
        run(3, 16'h0001, 1'b0);                  // k = 41..43
        run(8, 16'h0005, 1'b0);                  // k = 44..51

        // Back-to-back loads: last wins, 1111 never visible.
        run(1, 16'h0005, 1'b0);                  // k = 52
        ldcyc(16'h1111, 1'b0, 16'h0005, 1'b0);   // k = 53
        ldcyc(16'h2222, 1'b0, 16'h0005, 1'b0);   // k = 54
        run(1, 16'h0005, 1'b0);                  // k = 55
        run(16, 16'h2222, 1'b0);                 // k = 56..71

        // Pending ABCD discarded by reset at count 2 of DIG2.
        run(1, 16'h2222, 1'b0);                  // k = 72
        ldcyc(16'hABCD, 1'b1, 16'h2222, 1'b0);   // k = 73
        run(1, 16'h2222, 1'b0);                  // k = 74
        step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        run(8, 16'h0000, 1'b0);                  // k = 1..8, first tick at k = 4

        // Leading-zero candidate value 0040.
        ldcyc(16'h0040, 1'b0, 16'h0000, 1'b0);   // k = 9
        run(2, 16'h0000, 1'b0);                  // k = 10..11
        run(16, 16'h0040, 1'b0);                 // k = 12..27

        repeat (2) @(negedge clk);
        #1;
        n_chk = n_chk + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
